booth_mult_seq: RTL

- Parametrised, iterative radix-4 Booth multiplier. Next generation of the team's combinational N-bit Booth array.
- Retires one Booth digit per clock into a 2N-bit accumulator instead of instantiating N/2 ripple adders.
- Adds a per-operation signed/unsigned mode and valid/ready handshakes on input and output.
- Used wherever a multiply can tolerate multi-cycle latency in exchange for area.

---
 rtl/booth_mult_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: retires one Booth digit per clock into a 2N-bit accumulator.
// Signed/unsigned mode is chosen per operation; operands use valid/ready handshakes in and out.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | retiring Booth digits j = 0 .. N/2, one per clock
// DONE  | product valid on Mul, held until out_ready
module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   in2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Mul
);
    localparam int JW = $clog2(N / 2 + 1);
    localparam logic [JW-1:0] LAST_J = JW'(N / 2);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*N-1:0] a_ext, acc, pp, acc_nxt;
    logic [N+2:0]   b_ext;
    logic [JW-1:0]  j;
    logic [2:0]     trip;
    logic           accept, last_digit;

    always_comb begin
        in_ready   = (state == IDLE) && !rst;
        accept     = in_valid && in_ready;
        last_digit = (j == LAST_J);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (last_digit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // b_ext[k+1] holds Booth bit B[k], so the triplet for digit j sits at bits 2j+2..2j.
    always_comb begin
        trip = 3'(b_ext >> {j, 1'b0});
        pp   = '0;
        case (trip)
            3'd1, 3'd2: pp = a_ext;
            3'd3:       pp = a_ext << 1;
            3'd4:       pp = -(a_ext << 1);
            3'd5, 3'd6: pp = -a_ext;
            default:    pp = '0;
        endcase
        acc_nxt = acc + (pp << {j, 1'b0});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext     <= '0;
            b_ext     <= '0;
            acc       <= '0;
            j         <= '0;
            Mul       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_ext <= signed_mode ? {{N{A[N-1]}}, A} : {{N{1'b0}}, A};
                        b_ext <= {(signed_mode ? {2{in2[N-1]}} : 2'b00), in2, 1'b0};
                        acc   <= '0;
                        j     <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    j   <= j + 1'b1;
                    if (last_digit) begin
                        Mul       <= acc_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
